// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
// Optional write-to-read bypass is selected with RF_BYPASS_EN (see regfile_read_mux).
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Returns a 64-bit word; the caller casts it down to DATA_W.
  function automatic logic [63:0] init_value(input int mode, input logic [31:0] idx);
    return (mode == INIT_INDEX) ? {32'b0, idx} : 64'b0;
  endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One asynchronous read port: zero-register masking, INIT blanking and,
// when RF_BYPASS_EN is defined, same-cycle forwarding from the write ports.
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          run,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [NUM_WR-1:0]             we,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]             rd_data
);

  logic is_zero;
  assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

  always_comb begin
    rd_data = '0;
    if (run && !is_zero) begin
      rd_data = mem[rd_addr];
`ifdef RF_BYPASS_EN
      // Ascending scan so the highest-index matching port wins.
      for (int k = 0; k < NUM_WR; k++)
        if (we[k] && (wr_addr[k] == rd_addr)) rd_data = wr_data[k];
`endif
    end
  end

`ifndef RF_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{we, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardware init sequencer and
// prioritised write ports. Optional bypass: define RF_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  output logic                       ready,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               init_cnt_q, init_cnt_d;
  logic                            wr_conflict_q, wr_conflict_d;
  logic [DEPTH-1:0][DATA_W-1:0]    mem_q, mem_d;

  logic [NUM_WR-1:0][ADDR_W-1:0]   wa;
  logic [NUM_WR-1:0][DATA_W-1:0]   wd;
  logic [NUM_RD-1:0][ADDR_W-1:0]   ra;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_arr;
  logic [DATA_W-1:0]               init_word;

  assign wa          = wr_addr;
  assign wd          = wr_data;
  assign ra          = rd_addr;
  assign rd_data     = rd_arr;
  assign ready       = (state_q == ST_RUN);
  assign wr_conflict = wr_conflict_q;
  assign init_word   = DATA_W'(init_value(INIT_MODE, 32'(init_cnt_q)));

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    mem_d         = mem_q;
    wr_conflict_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_d[init_cnt_q] = init_word;
        init_cnt_d        = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr_req) begin
          // Writes in the clear cycle are discarded along with the contents.
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end else begin
          for (int k = 0; k < NUM_WR; k++)
            if (we[k] && writable(wa[k])) mem_d[wa[k]] = wd[k];
          for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
              if (we[i] && we[j] && (wa[i] == wa[j]) && writable(wa[i]))
                wr_conflict_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Storage is deliberately not reset; the init sequencer defines it.
  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .run    (ready),
      .rd_addr(ra[p]),
      .mem    (mem_q),
      .we     (we),
      .wr_addr(wa),
      .wr_data(wd),
      .rd_data(rd_arr[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed + randomized check of regfile_mp (2 read, 2 write, ZERO_REG, INIT_MODE=index)
// against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEP = 32;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               clr_req;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NW-1:0]      we;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*DW-1:0]   wr_data;
  logic               ready;
  logic               wr_conflict;

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .INIT_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] model [DEP];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < DEP; i++) model[i] = DW'(i);
  endtask

  // Expected read value in RUN, from the model plus the same-cycle write ports.
  function automatic logic [DW-1:0] exp_rd(input int a, input logic [NW-1:0] w,
                                           input int a0, input int a1,
                                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    if (a == 0) return '0;
    if (BYP && w[1] && a1 == a) return d1;
    if (BYP && w[0] && a0 == a) return d0;
    return model[a];
  endfunction

  task automatic drive_wr(input logic [NW-1:0] w, input int a0, input int a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    we      = w;
    wr_addr = {AW'(a1), AW'(a0)};
    wr_data = {d1, d0};
  endtask

  task automatic set_rd(input int r0, input int r1);
    rd_addr = {AW'(r1), AW'(r0)};
  endtask

  // Counts edges until ready rises; bounded so a stuck DUT still terminates.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 60) begin
      step();
      n++;
      if (n == 5) check({tag, "_rd_in_init"}, rd_data[DW-1:0], '0);
    end
    check({tag, "_latency"}, DW'(n), DW'(DEP));
  endtask

  initial begin
    int a0, a1, r0, r1;
    logic [NW-1:0] w;
    logic [DW-1:0] d0, d1;
    logic exp_conf;

    rst = 1'b1; clr_req = 1'b0;
    drive_wr(2'b00, 0, 0, '0, '0);
    set_rd(7, 0);
    step(); step();
    check("rst_ready", DW'(ready), 0);
    check("rst_conflict", DW'(wr_conflict), 0);
    check("rst_rd0", rd_data[DW-1:0], '0);

    rst = 1'b0;
    wait_ready("init");
    model_init();
    check("init_addr7", rd_data[DW-1:0], 32'd7);
    check("init_addr0", rd_data[2*DW-1:DW], '0);

    // Write to addr 5, observe same cycle then next cycle
    set_rd(5, 5);
    drive_wr(2'b01, 5, 0, 32'hDEADBEEF, '0);
    #1 check("wr5_same", rd_data[DW-1:0], BYP ? 32'hDEADBEEF : 32'd5);
    step(); model[5] = 32'hDEADBEEF;
    drive_wr(2'b00, 0, 0, '0, '0);
    #1 check("wr5_next", rd_data[DW-1:0], 32'hDEADBEEF);

    // Zero register
    set_rd(0, 0);
    drive_wr(2'b01, 0, 0, 32'h1234, '0);
    #1 check("zero_same", rd_data[DW-1:0], '0);
    step();
    drive_wr(2'b00, 0, 0, '0, '0);
    #1 check("zero_next", rd_data[DW-1:0], '0);

    // Both ports hit addr 9
    set_rd(9, 1);
    drive_wr(2'b11, 9, 9, 32'hAAAA, 32'h5555);
    #1 check("dual_same", rd_data[DW-1:0], BYP ? 32'h5555 : 32'd9);
    step(); model[9] = 32'h5555;
    drive_wr(2'b00, 0, 0, '0, '0);
    #1 check("dual_rd9", rd_data[DW-1:0], 32'h5555);
    check("dual_conf1", DW'(wr_conflict), 1);
    step();
    check("dual_conf0", DW'(wr_conflict), 0);

    // Both ports on addr 0 never raise a conflict
    drive_wr(2'b11, 0, 0, 32'h1, 32'h2);
    step();
    drive_wr(2'b00, 0, 0, '0, '0);
    #1 check("zero_noconf", DW'(wr_conflict), 0);

    // clr_req with a simultaneous write
    set_rd(3, 5);
    clr_req = 1'b1;
    drive_wr(2'b01, 3, 0, 32'hFF, '0);
    step();
    clr_req = 1'b0;
    drive_wr(2'b00, 0, 0, '0, '0);
    check("clr_ready0", DW'(ready), 0);
    wait_ready("clr");
    model_init();
    check("clr_addr3", rd_data[DW-1:0], 32'd3);
    check("clr_addr5", rd_data[2*DW-1:DW], 32'd5);

    // rst at init_cnt == 10
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_init_ready", DW'(ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rd(7, 31);
    wait_ready("rst_mid");
    model_init();
    check("rst_mid_7", rd_data[DW-1:0], 32'd7);
    check("rst_mid_31", rd_data[2*DW-1:DW], 32'd31);

    // Randomized traffic against the model
    exp_conf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      w  = NW'($urandom_range(0, 3));
      a0 = int'($urandom_range(0, DEP - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, DEP - 1));
      d0 = $urandom;
      d1 = $urandom;
      r0 = ($urandom_range(0, 2) == 0) ? a0 : int'($urandom_range(0, DEP - 1));
      r1 = ($urandom_range(0, 2) == 0) ? a1 : int'($urandom_range(0, DEP - 1));
      drive_wr(w, a0, a1, d0, d1);
      set_rd(r0, r1);
      #1;
      check("rnd_rd0", rd_data[DW-1:0], exp_rd(r0, w, a0, a1, d0, d1));
      check("rnd_rd1", rd_data[2*DW-1:DW], exp_rd(r1, w, a0, a1, d0, d1));
      check("rnd_conf", DW'(wr_conflict), DW'(exp_conf));
      exp_conf = w[0] && w[1] && (a0 == a1) && (a0 != 0);
      if (w[0] && a0 != 0) model[a0] = d0;
      if (w[1] && a1 != 0) model[a1] = d1;
      step();
    end
    drive_wr(2'b00, 0, 0, '0, '0);
    #1 check("rnd_conf_last", DW'(wr_conflict), DW'(exp_conf));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
